// File: rtl/boot_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package boot_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } boot_state_t;

    // Number of length bytes at the head of a frame
    localparam int LEN_BYTES = 2;

    // Largest byte array the checksum helper can walk
    localparam int CHK_MAX_BYTES = 2048;

    typedef logic [7:0] byte_arr_t [CHK_MAX_BYTES];

    // XOR of the first n bytes of an array; a frame's CHK byte is this value
    // taken over every byte that precedes it.
    function automatic logic [7:0] xor_checksum(input byte_arr_t bytes, input int unsigned n);
        logic [7:0] acc;
        acc = 8'h00;
        for (int unsigned i = 0; i < CHK_MAX_BYTES; i++) begin
            if (i < n) acc = acc ^ bytes[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/boot_byte_writer.sv
// Registered instruction-memory byte write stage plus the payload byte counter.
// Latency: one cycle from an accepted payload byte to its mem_we pulse.
// Backpressure: none; one write per accepted byte, the caller gates wr_en.
module boot_byte_writer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              clr,
    input  logic [7:0]        wr_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [CNT_W+1:0]  count
);

    // Write strobe is a single-cycle pulse; address is the count of bytes already written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            count     <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= wr_byte;
            end
            if (clr) begin
                count <= '0;
            end else if (wr_en) begin
                count <= count + (CNT_W+2)'(1);
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked byte frame into instruction memory, then releases core reset.
// Latency: memory write one cycle after each payload byte; RUN/ERROR visible the cycle after CHK.
// Backpressure: in_ready is high while loading and low in RUN/ERROR; reload wins over a same-cycle byte.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    // Memory capacity expressed at the width of 4*N so the size check never truncates
    localparam logic [CNT_W+1:0] MAX_BYTES = (CNT_W+2)'(1) << ADDR_W;

    boot_state_t      state;
    boot_state_t      state_nxt;
    logic             accept;
    logic             wr_en;
    logic             cnt_clr;
    logic [7:0]       acc;
    logic [7:0]       len_hi;
    logic [CNT_W-1:0] len_word;
    logic [CNT_W+1:0] total_new;
    logic [CNT_W+1:0] total;
    logic [CNT_W+1:0] count;

    assign accept    = in_valid && in_ready && !reload;
    assign len_word  = CNT_W'({len_hi, in_data});
    assign total_new = {len_word, 2'b00};
    assign wr_en     = accept && (state == ST_DATA);
    assign cnt_clr   = reload || (accept && (state == ST_LEN_LO));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: reload overrides everything, otherwise advance only on an accepted byte
    always_comb begin
        state_nxt = state;
        if (reload) begin
            state_nxt = ST_IDLE;
        end else if (accept) begin
            case (state)
                ST_IDLE:   state_nxt = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (total_new > MAX_BYTES)   state_nxt = ST_ERROR;
                    else if (len_word == '0)     state_nxt = ST_CHECK;
                    else                         state_nxt = ST_DATA;
                end
                ST_DATA:   if (count == total - (CNT_W+2)'(1)) state_nxt = ST_CHECK;
                ST_CHECK:  state_nxt = (in_data == acc) ? ST_RUN : ST_ERROR;
                default:   state_nxt = state;
            endcase
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_LEN_LO) ||
                    (state == ST_DATA) || (state == ST_CHECK);
        core_rst  = (state != ST_RUN);
        load_done = (state == ST_RUN);
        load_err  = (state == ST_ERROR);
    end

    // Checksum accumulator, high length byte and frame byte total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= 8'h00;
            len_hi <= 8'h00;
            total  <= '0;
        end else if (reload) begin
            acc <= 8'h00;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                acc    <= in_data;
                len_hi <= in_data;
            end else begin
                acc <= acc ^ in_data;
            end
            if (state == ST_LEN_LO) total <= total_new;
        end
    end

    boot_byte_writer #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_writer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .clr       (cnt_clr),
        .wr_byte   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count)
    );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames against a frame-level model.
// Latency: checks sample #1 after each rising edge.
// Backpressure: the model predicts how many bytes each frame consumes and only that many are offered.
module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W = 8;
    localparam int MAXB   = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] obs_mem   [MAXB];
    logic [7:0] model_mem [MAXB];
    int         wr_count;
    int         wr_addr_q [$];
    byte_arr_t  frame;

    logic [7:0] t_good [7] = '{8'h00, 8'h01, 8'h8C, 8'h80, 8'h00, 8'h00, 8'h0D};
    logic [7:0] t_bad  [7] = '{8'h00, 8'h01, 8'h8C, 8'h80, 8'h00, 8'h00, 8'h0C};

    imem_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Instruction memory as seen by a posedge-write RAM: a strobe still high mid-cycle is a write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_mem[mem_addr] = mem_wdata;
            wr_count++;
            wr_addr_q.push_back(int'(mem_addr));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic clear_capture();
        wr_count = 0;
        wr_addr_q.delete();
    endtask

    task automatic check_image(input string tag);
        int diffs;
        int order_err;
        diffs = 0;
        order_err = 0;
        for (int a = 0; a < MAXB; a++) if (obs_mem[a] !== model_mem[a]) diffs++;
        for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] != i) order_err++;
        chk({tag, "_mem_image"}, 32'(diffs), 32'd0);
        chk({tag, "_wr_order"}, 32'(order_err), 32'd0);
    endtask

    // Frame-level reference: outcome follows from N, the size limit and the checksum rule alone
    task automatic run_frame(input int n, input bit bad, input int gap_mode, input string tag);
        int         total;
        int         consumed;
        int         exp_writes;
        bit         exp_err;
        logic [7:0] c;
        pulse_reload();
        clear_capture();
        total    = 4 * n;
        frame[0] = 8'(n >> 8);
        frame[1] = 8'(n);
        if (total > MAXB) begin
            exp_err    = 1'b1;
            consumed   = LEN_BYTES;
            exp_writes = 0;
        end else begin
            for (int i = 0; i < total; i++) begin
                frame[LEN_BYTES + i] = 8'($urandom);
                model_mem[i]         = frame[LEN_BYTES + i];
            end
            c = xor_checksum(frame, 32'(LEN_BYTES + total));
            if (bad) c = c ^ 8'($urandom_range(1, 255));
            frame[LEN_BYTES + total] = c;
            consumed   = LEN_BYTES + total + 1;
            exp_writes = total;
            exp_err    = bad;
        end
        for (int i = 0; i < consumed; i++) send_byte(frame[i], gap_mode);
        chk({tag, "_load_done"}, 32'(load_done), 32'(!exp_err));
        chk({tag, "_load_err"}, 32'(load_err), 32'(exp_err));
        chk({tag, "_core_rst"}, 32'(core_rst), 32'(exp_err));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'(exp_writes));
        check_image(tag);
    endtask

    initial begin
        int n;
        for (int a = 0; a < MAXB; a++) begin
            obs_mem[a]   = 8'h00;
            model_mem[a] = 8'h00;
        end
        clear_capture();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        tick();

        // Good single word, write timing checked byte by byte
        clear_capture();
        for (int i = 0; i < 7; i++) begin
            send_byte(t_good[i], 0);
            if (i >= 2 && i <= 5) begin
                chk("good_we", 32'(mem_we), 32'd1);
                chk("good_addr", 32'(mem_addr), 32'(i - 2));
                chk("good_wdata", 32'(mem_wdata), 32'(t_good[i]));
                model_mem[i - 2] = t_good[i];
            end else begin
                chk("good_we_idle", 32'(mem_we), 32'd0);
            end
            if (i < 6) chk("good_core_rst_held", 32'(core_rst), 32'd1);
        end
        chk("good_core_rst", 32'(core_rst), 32'd0);
        chk("good_load_done", 32'(load_done), 32'd1);
        chk("good_wr_count", 32'(wr_count), 32'd4);
        check_image("good");
        // Bytes offered in RUN are ignored
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("run_ignore_we", 32'(wr_count), 32'd4);
        chk("run_ignore_done", 32'(load_done), 32'd1);

        // Bad checksum
        pulse_reload();
        clear_capture();
        for (int i = 0; i < 7; i++) send_byte(t_bad[i], 0);
        chk("bad_wr_count", 32'(wr_count), 32'd4);
        chk("bad_load_err", 32'(load_err), 32'd1);
        chk("bad_core_rst", 32'(core_rst), 32'd1);
        chk("bad_in_ready", 32'(in_ready), 32'd0);
        check_image("bad");
        pulse_reload();
        chk("bad_reload_err", 32'(load_err), 32'd0);
        chk("bad_reload_ready", 32'(in_ready), 32'd1);
        chk("bad_reload_core_rst", 32'(core_rst), 32'd1);

        // Reload wins over a same-cycle byte: FF must not become LEN_HI
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        reload   = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        chk("prio_load_done", 32'(load_done), 32'd1);
        chk("prio_load_err", 32'(load_err), 32'd0);

        // Empty frame, then reload from RUN
        run_frame(0, 1'b0, 0, "empty");
        pulse_reload();
        chk("empty_reload_core_rst", 32'(core_rst), 32'd1);
        chk("empty_reload_ready", 32'(in_ready), 32'd1);
        chk("empty_reload_done", 32'(load_done), 32'd0);

        // Overflow: 0x41 words exceeds 256 bytes
        clear_capture();
        send_byte(8'h00, 0);
        chk("ovf_first_err", 32'(load_err), 32'd0);
        chk("ovf_first_ready", 32'(in_ready), 32'd1);
        send_byte(8'h41, 0);
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_core_rst", 32'(core_rst), 32'd1);
        repeat (3) tick();
        chk("ovf_no_writes", 32'(wr_count), 32'd0);

        // Exactly full memory
        run_frame(64, 1'b0, 0, "full");
        chk("full_last_addr", (wr_addr_q.size() > 0) ? 32'(wr_addr_q[$]) : 32'hFFFF_FFFF, 32'hFF);

        // Six words with in_valid toggling
        run_frame(6, 1'b0, 1, "gap");

        // Reset after ten payload bytes
        pulse_reload();
        clear_capture();
        frame[0] = 8'h00;
        frame[1] = 8'h06;
        for (int i = 0; i < 24; i++) frame[LEN_BYTES + i] = 8'($urandom);
        for (int i = 0; i < LEN_BYTES + 10; i++) send_byte(frame[i], 1);
        chk("mid_we_before_rst", 32'(mem_we), 32'd1);
        chk("mid_addr_before_rst", 32'(mem_addr), 32'd9);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_done", 32'(load_done), 32'd0);
        chk("mid_rst_err", 32'(load_err), 32'd0);
        // The tenth strobe is cut before the RAM edge, so nine bytes land
        for (int i = 0; i < 9; i++) model_mem[i] = frame[LEN_BYTES + i];
        tick();
        tick();
        chk("mid_wr_count", 32'(wr_count), 32'd9);
        check_image("mid");
        rst = 1'b0;
        tick();
        run_frame(6, 1'b0, 1, "after_rst");

        // Randomized frames: sizes, checksum corruption, overflow and gaps
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 4) == 0) n = int'($urandom_range(65, 65535));
            else                           n = int'($urandom_range(0, 64));
            run_frame(n, ($urandom_range(0, 3) == 0), 2, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for mips_top's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes each word big-endian (MSB byte at the lowest address), byte by byte, into instruction memory.
- Holds the core in reset until a frame with a valid checksum has been fully loaded, then releases it.
- Replaces bench-side hierarchical preloading of instruction memory with a synthesizable load path.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory; capacity MAX_BYTES = 2**ADDR_W.
- CNT_W, 16, width of the frame word-count field (fixed to two length bytes).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  incoming frame byte.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid and in_ready are both high.
- reload  in  1  single-cycle request to re-enter load mode.
- mem_we  out  1  instruction-memory byte write strobe.
- mem_addr  out  ADDR_W  byte address for the write.
- mem_wdata  out  8  byte to write.
- core_rst  out  1  reset to mips_top; high while not running.
- load_done  out  1  high in RUN.
- load_err  out  1  sticky error flag.

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4*N payload bytes, then CHK.
  - CHK must equal the XOR of all preceding frame bytes, including both length bytes.
- State machine states: IDLE, LEN_LO, DATA, CHECK, RUN, ERROR.
- On rst: state=IDLE, core_rst=1, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_err=0, checksum accumulator=0, byte counter=0. in_ready=1 (combinational decode of IDLE).
- in_ready=1 in IDLE, LEN_LO, DATA and CHECK; 0 in RUN and ERROR.
- States advance only on an accepted byte. Gaps in in_valid stall the FSM without side effects.
- IDLE: accept LEN_HI; acc=byte; go to LEN_LO.
- LEN_LO: accept LEN_LO and form N.
  - If 4*N > MAX_BYTES (compare at CNT_W+2 bits, no truncation): go to ERROR.
  - Else if N=0: go to CHECK.
  - Else: go to DATA with counter=0.
- DATA: for each accepted byte:
  - Next cycle (1-cycle registered latency): mem_we=1, mem_addr=counter, mem_wdata=byte.
  - acc ^= byte; counter increments.
  - After byte 4*N-1, go to CHECK.
  - mem_we is a one-cycle pulse per accepted byte.
- CHECK: accept CHK.
  - If CHK == acc: go to RUN; core_rst=0 and load_done=1 from the next cycle.
  - Else: go to ERROR with load_err=1.
- RUN: no memory writes; in_valid is ignored.
- ERROR: core_rst=1, load_err=1.
- reload, sampled in any state: next cycle state=IDLE, core_rst=1, load_done=0, load_err=0, acc=0, counter=0.
  - reload takes priority over a byte transfer in the same cycle; that byte is not accepted.
  - A pending mem_we from the previous cycle still completes.
- Memory contents beyond 4*N are untouched; earlier contents persist across reloads.
- Asserting rst mid-frame aborts immediately: all outputs go to their reset values asynchronously. A partially written memory is not cleared.
- Address wrap-around cannot occur, because the overflow check rejects any frame larger than MAX_BYTES.
  - N such that 4*N == MAX_BYTES is legal and fills addresses 0..MAX_BYTES-1.

Decomposition:
- Shared package boot_pkg holds:
  - FSM state enum (6 states, 3 bits);
  - LEN_BYTES=2 constant;
  - a function computing the XOR checksum over a byte array, reused by the bench.
- One sub-module is natural: boot_byte_writer, holding the registered mem_we/mem_addr/mem_wdata stage and the byte counter. The FSM stays in the top level.

Test Plan:
- Good single word: stream 00 01 8C 80 00 00 0D.
  - Required: writes addr0=8C, addr1=80, addr2=00, addr3=00, each one cycle after acceptance.
  - core_rst falls and load_done rises the cycle after 0D is accepted.
- Bad checksum: same frame with 0C as CHK.
  - Required: 4 writes occur, load_err=1, core_rst stays 1, in_ready=0.
  - reload then returns to IDLE with load_err=0.
- Overflow (ADDR_W=8): stream 00 41.
  - Required: ERROR entered after the second byte, no mem_we ever asserted.
  - Also check that 00 40 plus 256 payload bytes plus correct CHK reaches RUN with the last write at addr 0xFF.
- Empty frame: stream 00 00 00 -> RUN with zero writes.
  - In RUN, pulse reload: core_rst=1 the next cycle, in_ready=1.
- Handshake gaps and reset: send the 6-word program (24 bytes, N=6) with in_valid toggling every other cycle.
  - Required: exactly 24 writes at addresses 0..23.
  - Repeat, asserting rst after 10 payload bytes: outputs reach reset values immediately, and a fresh full frame then loads correctly.
